// File: rtl/fpu_pkg.sv
// ============================================================================
//  Module      : fpu_pkg
//  Description : Shared encodings for the FSQRT.S sequencer and its rounder.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

package fpu_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_UNPACK = 3'd1;
  localparam logic [2:0] ST_NORM   = 3'd2;
  localparam logic [2:0] ST_ITER   = 3'd3;
  localparam logic [2:0] ST_ROUND  = 3'd4;
  localparam logic [2:0] ST_DONE   = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE   = ST_IDLE,
    S_UNPACK = ST_UNPACK,
    S_NORM   = ST_NORM,
    S_ITER   = ST_ITER,
    S_ROUND  = ST_ROUND,
    S_DONE   = ST_DONE
  } state_e;

  localparam logic [31:0] CANON_NAN = 32'h7FC0_0000;

  localparam int FLAG_NV = 4;
  localparam int FLAG_DZ = 3;
  localparam int FLAG_OF = 2;
  localparam int FLAG_UF = 1;
  localparam int FLAG_NX = 0;

  localparam logic [2:0] RM_RNE = 3'b000;
  localparam logic [2:0] RM_RTZ = 3'b001;
  localparam logic [2:0] RM_RDN = 3'b010;
  localparam logic [2:0] RM_RUP = 3'b011;
  localparam logic [2:0] RM_RMM = 3'b100;

endpackage

`default_nettype wire

// File: rtl/sqrt_rounder.sv
// ============================================================================
//  Module      : sqrt_rounder
//  Description : Combinational round-increment decision from {L,G,R,S}.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module sqrt_rounder
  import fpu_pkg::*;
(
  input  logic       sign_i,
  input  logic [2:0] rm_i,
  input  logic [3:0] lgrs_i,
  output logic       round_o,
  output logic       inexact_o
);

  logic l_bit;
  logic g_bit;
  logic r_bit;
  logic s_bit;

  always_comb begin
    l_bit     = lgrs_i[3];
    g_bit     = lgrs_i[2];
    r_bit     = lgrs_i[1];
    s_bit     = lgrs_i[0];
    inexact_o = g_bit | r_bit | s_bit;
    round_o   = 1'b0;
    case (rm_i)
      RM_RNE:  round_o = g_bit & (l_bit | r_bit | s_bit);
      RM_RTZ:  round_o = 1'b0;
      RM_RDN:  round_o = sign_i & (g_bit | r_bit | s_bit);
      RM_RUP:  round_o = ~sign_i & (g_bit | r_bit | s_bit);
      RM_RMM:  round_o = g_bit;
      // Reserved encodings truncate.
      default: round_o = 1'b0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/fpu_sqrt_seq.sv
// ============================================================================
//  Module      : fpu_sqrt_seq
//  Description : Multi-cycle FSQRT.S sequencer, radix-2 restoring root loop.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module fpu_sqrt_seq
  import fpu_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int BIAS  = 127
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        kill_i,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic [31:0] operand_i,
  input  logic [2:0]  rm_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [31:0] result_o,
  output logic [4:0]  flags_o
);

  localparam int RL  = MAN_W + 3;
  localparam int MW  = MAN_W + 1;
  localparam int RW  = 2 * RL;
  localparam int EW  = EXP_W + 2;
  localparam int CW  = $clog2(RL);
  localparam int PAD = MAN_W + 4;

  localparam logic signed [EW-1:0] ONE_E  = EW'(1);
  localparam logic signed [EW-1:0] BIAS_E = EW'(BIAS);
  localparam logic signed [EW-1:0] EMIN_E = ONE_E - BIAS_E;

  state_e                 state_q, state_d;
  logic [31:0]            op_q, op_d;
  logic [2:0]             rm_q, rm_d;
  logic [MW-1:0]          mant_q, mant_d;
  logic signed [EW-1:0]   exp_q, exp_d;
  logic [RW-1:0]          rad_q, rad_d;
  logic [RL+2:0]          rem_q, rem_d;
  logic [RL-1:0]          root_q, root_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   out_valid_q, out_valid_d;
  logic [31:0]            result_q, result_d;
  logic [4:0]             flags_q, flags_d;

  logic                   op_sign;
  logic [EXP_W-1:0]       op_exp;
  logic [MAN_W-1:0]       op_man;
  logic [MW-1:0]          pre_mant;
  logic signed [EW-1:0]   pre_exp;
  logic                   pre_odd;
  logic [MW:0]            load_x;
  logic [RL+2:0]          rem_sh;
  logic [RL+2:0]          trial;
  logic                   trial_ge;
  logic [3:0]             lgrs;
  logic                   round_up;
  logic                   inexact;
  logic [MW-1:0]          man_sum;
  logic signed [EW-1:0]   res_exp;

  assign op_sign = op_q[EXP_W+MAN_W];
  assign op_exp  = op_q[EXP_W+MAN_W-1 -: EXP_W];
  assign op_man  = op_q[MAN_W-1:0];

  // Radicand seen on entry to ITER, from either the unpacked or the normalised operand.
  always_comb begin
    if (state_q == S_NORM) begin
      pre_mant = mant_q << 1;
      pre_exp  = exp_q - ONE_E;
    end else begin
      pre_mant = {1'b1, op_man};
      pre_exp  = $signed({{(EW-EXP_W){1'b0}}, op_exp}) - BIAS_E;
    end
    pre_odd = pre_exp[0];
    load_x  = pre_odd ? {pre_mant, 1'b0} : {1'b0, pre_mant};
  end

  always_comb begin
    rem_sh   = {rem_q[RL:0], rad_q[RW-1 -: 2]};
    trial    = {1'b0, root_q, 2'b01};
    trial_ge = (rem_sh >= trial);
  end

  assign lgrs = {root_q[2], root_q[1], root_q[0], |rem_q};

  sqrt_rounder u_rounder (
    .sign_i    (1'b0),
    .rm_i      (rm_q),
    .lgrs_i    (lgrs),
    .round_o   (round_up),
    .inexact_o (inexact)
  );

  always_comb begin
    man_sum = {1'b0, root_q[RL-2:2]} + MW'(round_up);
    res_exp = (exp_q >>> 1) + BIAS_E + $signed({{(EW-1){1'b0}}, man_sum[MW-1]});
  end

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    rm_d        = rm_q;
    mant_d      = mant_q;
    exp_d       = exp_q;
    rad_d       = rad_q;
    rem_d       = rem_q;
    root_d      = root_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    result_d    = result_q;
    flags_d     = flags_q;

    case (state_q)
      S_IDLE: begin
        if (in_valid_i) begin
          op_d    = operand_i;
          rm_d    = rm_i;
          state_d = S_UNPACK;
        end
      end

      S_UNPACK: begin
        if (&op_exp) begin
          state_d     = S_DONE;
          out_valid_d = 1'b1;
          flags_d     = '0;
          if (|op_man) begin
            result_d         = CANON_NAN;
            flags_d[FLAG_NV] = ~op_man[MAN_W-1];
          end else if (op_sign) begin
            result_d         = CANON_NAN;
            flags_d[FLAG_NV] = 1'b1;
          end else begin
            result_d = op_q;
          end
        end else if ((op_exp == '0) && (op_man == '0)) begin
          state_d     = S_DONE;
          out_valid_d = 1'b1;
          result_d    = op_q;
          flags_d     = '0;
        end else if (op_sign) begin
          state_d          = S_DONE;
          out_valid_d      = 1'b1;
          result_d         = CANON_NAN;
          flags_d          = '0;
          flags_d[FLAG_NV] = 1'b1;
        end else if (op_exp == '0) begin
          mant_d  = {1'b0, op_man};
          exp_d   = EMIN_E;
          state_d = S_NORM;
        end else begin
          rad_d   = {load_x, {PAD{1'b0}}};
          exp_d   = pre_odd ? pre_exp - ONE_E : pre_exp;
          rem_d   = '0;
          root_d  = '0;
          cnt_d   = '0;
          state_d = S_ITER;
        end
      end

      // Leave as soon as the shift about to happen lands the hidden bit.
      S_NORM: begin
        mant_d = pre_mant;
        exp_d  = pre_exp;
        if (mant_q[MW-2]) begin
          rad_d   = {load_x, {PAD{1'b0}}};
          exp_d   = pre_odd ? pre_exp - ONE_E : pre_exp;
          rem_d   = '0;
          root_d  = '0;
          cnt_d   = '0;
          state_d = S_ITER;
        end
      end

      S_ITER: begin
        rad_d  = rad_q << 2;
        rem_d  = trial_ge ? (rem_sh - trial) : rem_sh;
        root_d = {root_q[RL-2:0], trial_ge};
        if (cnt_q == CW'(RL - 1)) begin
          state_d = S_ROUND;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      S_ROUND: begin
        result_d         = {1'b0, res_exp[EXP_W-1:0],
                            man_sum[MW-1] ? {MAN_W{1'b0}} : man_sum[MAN_W-1:0]};
        flags_d          = '0;
        flags_d[FLAG_NX] = inexact;
        out_valid_d      = 1'b1;
        state_d          = S_DONE;
      end

      S_DONE: begin
        if (out_ready_i) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end

      default: begin
        state_d     = S_IDLE;
        out_valid_d = 1'b0;
      end
    endcase

    if (kill_i) begin
      state_d     = S_IDLE;
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= S_IDLE;
      op_q        <= '0;
      rm_q        <= '0;
      mant_q      <= '0;
      exp_q       <= '0;
      rad_q       <= '0;
      rem_q       <= '0;
      root_q      <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      flags_q     <= '0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      rm_q        <= rm_d;
      mant_q      <= mant_d;
      exp_q       <= exp_d;
      rad_q       <= rad_d;
      rem_q       <= rem_d;
      root_q      <= root_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      flags_q     <= flags_d;
    end
  end

  assign in_ready_o  = (state_q == S_IDLE);
  assign out_valid_o = out_valid_q;
  assign result_o    = result_q;
  assign flags_o     = flags_q;

endmodule

`default_nettype wire

// File: tb/tb_fpu_sqrt_seq.sv
// ============================================================================
//  Module      : tb_fpu_sqrt_seq
//  Description : Directed self-checking bench for the FSQRT.S sequencer.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_fpu_sqrt_seq;

  logic        clk;
  logic        reset_i;
  logic        kill_i;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [31:0] operand_i;
  logic [2:0]  rm_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [31:0] result_o;
  logic [4:0]  flags_o;

  int n_checks = 0;
  int n_errors = 0;

  fpu_sqrt_seq dut (
    .clk_i       (clk),
    .reset_i     (reset_i),
    .kill_i      (kill_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .operand_i   (operand_i),
    .rm_i        (rm_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .result_o    (result_o),
    .flags_o     (flags_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Issue one operand, measure accept-to-valid latency, check and consume the result.
  task automatic run_op(input string tag, input logic [31:0] op, input logic [2:0] rm,
                        input logic [31:0] exp_res, input logic [4:0] exp_flags,
                        input int exp_lat);
    int lat;
    check({tag, " in_ready"}, 32'(in_ready_o), 32'd1);
    in_valid_i = 1'b1;
    operand_i  = op;
    rm_i       = rm;
    @(posedge clk); #1;
    in_valid_i = 1'b0;
    lat = 1;
    while (!out_valid_o && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, " latency"}, 32'(lat), 32'(exp_lat));
    check({tag, " result"}, result_o, exp_res);
    check({tag, " flags"}, 32'(flags_o), 32'(exp_flags));
    @(posedge clk); #1;
    check({tag, " valid_drop"}, 32'(out_valid_o), 32'd0);
  endtask

  // Start a 9.0 op and abort it in the fifth ITER cycle with kill or reset.
  task automatic abort_in_iter(input logic use_reset);
    in_valid_i = 1'b1;
    operand_i  = 32'h4110_0000;
    rm_i       = 3'b000;
    @(posedge clk); #1;
    in_valid_i = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    if (use_reset) reset_i = 1'b1;
    else           kill_i  = 1'b1;
    @(posedge clk); #1;
    reset_i = 1'b0;
    kill_i  = 1'b0;
  endtask

  task automatic watch_no_valid(input string tag, input int cycles);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk); #1;
      seen = seen | out_valid_o;
    end
    check({tag, " no_valid"}, 32'(seen), 32'd0);
  endtask

  initial begin
    logic [31:0] held_res;
    logic [4:0]  held_flags;
    int          wait_cnt;

    reset_i     = 1'b1;
    kill_i      = 1'b0;
    in_valid_i  = 1'b0;
    operand_i   = '0;
    rm_i        = '0;
    out_ready_i = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset_i = 1'b0;
    @(posedge clk); #1;
    check("reset out_valid", 32'(out_valid_o), 32'd0);
    check("reset result", result_o, 32'd0);
    check("reset flags", 32'(flags_o), 32'd0);
    check("reset in_ready", 32'(in_ready_o), 32'd1);

    run_op("sqrt4",      32'h4080_0000, 3'b000, 32'h4000_0000, 5'b00000, 29);
    run_op("sqrt2 rne",  32'h4000_0000, 3'b000, 32'h3FB5_04F3, 5'b00001, 29);
    run_op("sqrt2 rup",  32'h4000_0000, 3'b011, 32'h3FB5_04F4, 5'b00001, 29);
    run_op("sqrt2 rtz",  32'h4000_0000, 3'b001, 32'h3FB5_04F3, 5'b00001, 29);
    run_op("sqrt2 rm7",  32'h4000_0000, 3'b111, 32'h3FB5_04F3, 5'b00001, 29);
    run_op("sqrt9",      32'h4110_0000, 3'b000, 32'h4040_0000, 5'b00000, 29);
    run_op("neg one",    32'hBF80_0000, 3'b000, 32'h7FC0_0000, 5'b10000, 2);
    run_op("snan",       32'h7F80_0001, 3'b000, 32'h7FC0_0000, 5'b10000, 2);
    run_op("qnan",       32'h7FC0_0000, 3'b000, 32'h7FC0_0000, 5'b00000, 2);
    run_op("neg zero",   32'h8000_0000, 3'b000, 32'h8000_0000, 5'b00000, 2);
    run_op("pos inf",    32'h7F80_0000, 3'b000, 32'h7F80_0000, 5'b00000, 2);
    run_op("neg inf",    32'hFF80_0000, 3'b000, 32'h7FC0_0000, 5'b10000, 2);
    run_op("subnormal",  32'h0000_0001, 3'b000, 32'h1A35_04F3, 5'b00001, 52);

    // Consumer stall: outputs frozen, new operand offered but not taken.
    out_ready_i = 1'b0;
    in_valid_i  = 1'b1;
    operand_i   = 32'h4080_0000;
    rm_i        = 3'b000;
    @(posedge clk); #1;
    operand_i = 32'h4110_0000;
    wait_cnt  = 1;
    while (!out_valid_o && wait_cnt < 200) begin
      @(posedge clk); #1;
      wait_cnt++;
    end
    check("stall latency", 32'(wait_cnt), 32'd29);
    held_res   = result_o;
    held_flags = flags_o;
    check("stall first result", held_res, 32'h4000_0000);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("stall valid", 32'(out_valid_o), 32'd1);
      check("stall result", result_o, held_res);
      check("stall flags", 32'(flags_o), 32'(held_flags));
      check("stall in_ready", 32'(in_ready_o), 32'd0);
    end
    out_ready_i = 1'b1;
    @(posedge clk); #1;
    in_valid_i = 1'b0;
    check("handshake valid_drop", 32'(out_valid_o), 32'd0);
    check("handshake in_ready", 32'(in_ready_o), 32'd1);
    run_op("after stall", 32'h4110_0000, 3'b000, 32'h4040_0000, 5'b00000, 29);

    abort_in_iter(1'b0);
    check("kill in_ready", 32'(in_ready_o), 32'd1);
    check("kill out_valid", 32'(out_valid_o), 32'd0);
    watch_no_valid("kill", 40);
    run_op("after kill", 32'h4110_0000, 3'b000, 32'h4040_0000, 5'b00000, 29);

    abort_in_iter(1'b1);
    check("rst in_ready", 32'(in_ready_o), 32'd1);
    check("rst out_valid", 32'(out_valid_o), 32'd0);
    check("rst result", result_o, 32'd0);
    check("rst flags", 32'(flags_o), 32'd0);
    watch_no_valid("rst", 40);
    run_op("after rst", 32'h4110_0000, 3'b000, 32'h4040_0000, 5'b00000, 29);

    // Kill coincident with an offered operand in IDLE must win.
    in_valid_i = 1'b1;
    kill_i     = 1'b1;
    operand_i  = 32'h4080_0000;
    @(posedge clk); #1;
    in_valid_i = 1'b0;
    kill_i     = 1'b0;
    check("kill+accept in_ready", 32'(in_ready_o), 32'd1);
    watch_no_valid("kill+accept", 35);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
